deadband_gen_mc: RTL and testbench

DEADBAND_GEN_MC -- requirements
Module: deadband_gen_mc

---
 rtl/deadband_gen_mc_pkg.sv | 15 +
 rtl/deadband_gen_mc_if.sv | 25 ++
 rtl/deadband_gen_mc_ch.sv | 115 +++++++++++
 rtl/deadband_gen_mc.sv | 63 ++++++
 tb/tb_deadband_gen_mc.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/deadband_gen_mc_pkg.sv
// rtl/deadband_gen_mc_pkg.sv - shared types and limits for the dead-band generator
package deadband_pkg;

  // Upper bound on the number of half-bridge channels one instance may drive
  localparam int NCH_MAX = 16;

  // Per-channel gate-drive state
  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_DEAD = 2'd1,
    ST_HI   = 2'd2,
    ST_LO   = 2'd3
  } ch_state_e;

endpackage

// File: rtl/deadband_gen_mc_if.sv
// rtl/deadband_gen_mc_if.sv - per-channel PWM command and gate-drive bundle
interface deadband_gen_mc_if #(
  parameter int NCH = 3
);

  logic [NCH-1:0] pwm_in;
  logic [NCH-1:0] pwm_high;
  logic [NCH-1:0] pwm_low;
  logic [NCH-1:0] dead_active;

  modport master (
    output pwm_in,
    input  pwm_high,
    input  pwm_low,
    input  dead_active
  );

  modport slave (
    input  pwm_in,
    output pwm_high,
    output pwm_low,
    output dead_active
  );

endinterface

// File: rtl/deadband_gen_mc_ch.sv
// rtl/deadband_gen_mc_ch.sv - one half-bridge channel: input sync, dead-time FSM, gate outputs
module deadband_ch
  import deadband_pkg::*;
#(
  parameter int DT_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                run_i,
  input  logic                pwm_i,
  input  logic [DT_WIDTH-1:0] dt_rise_i,
  input  logic [DT_WIDTH-1:0] dt_fall_i,
  output logic                pwm_high_o,
  output logic                pwm_low_o,
  output logic                dead_active_o
);

  ch_state_e           state_q, state_d;
  logic                pwm_s_q;
  logic                target_q, target_d;
  logic [DT_WIDTH-1:0] dt_sel_q, dt_sel_d;
  logic [DT_WIDTH-1:0] cnt_q, cnt_d;
  logic                high_q, low_q, dead_q;

  logic [DT_WIDTH-1:0] dt_new;
  logic [DT_WIDTH-1:0] dt_last;
  logic                dead_done;

  // Dead time is picked by the side about to conduct; a zero setting still
  // gives one dead cycle, so the last count index is max(dt_sel,1)-1.
  assign dt_new    = pwm_s_q ? dt_rise_i : dt_fall_i;
  assign dt_last   = (dt_sel_q == '0) ? '0 : dt_sel_q - DT_WIDTH'(1);
  assign dead_done = (cnt_q >= dt_last);

  // Next-state logic: forced off first, then edge (re)start, then dead count
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    dt_sel_d = dt_sel_q;
    cnt_d    = cnt_q;
    if (!run_i) begin
      state_d = ST_OFF;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d  = ST_DEAD;
          target_d = pwm_s_q;
          dt_sel_d = dt_new;
          cnt_d    = '0;
        end
        ST_HI: begin
          if (!pwm_s_q) begin
            state_d  = ST_DEAD;
            target_d = 1'b0;
            dt_sel_d = dt_new;
            cnt_d    = '0;
          end
        end
        ST_LO: begin
          if (pwm_s_q) begin
            state_d  = ST_DEAD;
            target_d = 1'b1;
            dt_sel_d = dt_new;
            cnt_d    = '0;
          end
        end
        ST_DEAD: begin
          if (pwm_s_q != target_q) begin
            target_d = pwm_s_q;
            dt_sel_d = dt_new;
            cnt_d    = '0;
          end else if (dead_done) begin
            state_d = target_q ? ST_HI : ST_LO;
            cnt_d   = '0;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + DT_WIDTH'(1);
          end
        end
        default: begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, command sync and gate outputs decoded from the next state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_OFF;
      pwm_s_q  <= 1'b0;
      target_q <= 1'b0;
      dt_sel_q <= '0;
      cnt_q    <= '0;
      high_q   <= 1'b0;
      low_q    <= 1'b0;
      dead_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pwm_s_q  <= pwm_i;
      target_q <= target_d;
      dt_sel_q <= dt_sel_d;
      cnt_q    <= cnt_d;
      high_q   <= (state_d == ST_HI);
      low_q    <= (state_d == ST_LO);
      dead_q   <= (state_d == ST_DEAD);
    end
  end

  assign pwm_high_o    = high_q;
  assign pwm_low_o     = low_q;
  assign dead_active_o = dead_q;

endmodule

// File: rtl/deadband_gen_mc.sv
// rtl/deadband_gen_mc.sv - multi-channel dead-band generator with shared fault trip and enable
module deadband_gen_mc
  import deadband_pkg::*;
#(
  parameter int NCH      = 3,
  parameter int DT_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [DT_WIDTH-1:0] dt_rise,
  input  logic [DT_WIDTH-1:0] dt_fall,
  input  logic                fault_n,
  input  logic                fault_clr,
  output logic                fault_latched,
  deadband_gen_mc_if.slave    bus
);

  logic fault_q, fault_d;
  logic run;

  // A trip acts on the very edge that samples it, so the raw fault_n also
  // gates the channels; the latch then holds them off until cleared.
  assign run = enable & fault_n & ~fault_q;

  // Fault latch: set wins over clear
  always_comb begin
    fault_d = fault_q;
    if (!fault_n) begin
      fault_d = 1'b1;
    end else if (fault_clr) begin
      fault_d = 1'b0;
    end
  end

  // Fault status register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign fault_latched = fault_q;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    deadband_ch #(
      .DT_WIDTH (DT_WIDTH)
    ) u_ch (
      .clk           (clk),
      .reset_n       (reset_n),
      .run_i         (run),
      .pwm_i         (bus.pwm_in[i]),
      .dt_rise_i     (dt_rise),
      .dt_fall_i     (dt_fall),
      .pwm_high_o    (bus.pwm_high[i]),
      .pwm_low_o     (bus.pwm_low[i]),
      .dead_active_o (bus.dead_active[i])
    );
  end

endmodule

// File: tb/tb_deadband_gen_mc.sv
// tb/tb_deadband_gen_mc.sv - directed and randomised checks of deadband_gen_mc
module tb_deadband_gen_mc;

  localparam int NCH = 3;
  localparam int DTW = 8;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           enable;
  logic [DTW-1:0] dt_rise;
  logic [DTW-1:0] dt_fall;
  logic           fault_n;
  logic           fault_clr;
  logic           fault_latched;

  int checks   = 0;
  int failures = 0;

  bit mon_en = 1'b0;
  int off_cnt [NCH];
  logic [NCH-1:0] prev_high = '0;
  logic [NCH-1:0] prev_low  = '0;

  deadband_gen_mc_if #(.NCH(NCH)) bus ();

  deadband_gen_mc #(
    .NCH      (NCH),
    .DT_WIDTH (DTW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .dt_rise       (dt_rise),
    .dt_fall       (dt_fall),
    .fault_n       (fault_n),
    .fault_clr     (fault_clr),
    .fault_latched (fault_latched),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [NCH-1:0] hi,
                         input logic [NCH-1:0] lo, input logic [NCH-1:0] dd);
    check_eq({tag, ".high"}, 32'(bus.pwm_high), 32'(hi));
    check_eq({tag, ".low"},  32'(bus.pwm_low),  32'(lo));
    check_eq({tag, ".dead"}, 32'(bus.dead_active), 32'(dd));
  endtask

  // Continuous overlap check plus dead-gap check on every turn-on while the
  // random phase holds dt_rise/dt_fall constant.
  always @(negedge clk) begin
    if (reset_n) begin
      check_eq("no_overlap", 32'(bus.pwm_high & bus.pwm_low), 32'd0);
      for (int c = 0; c < NCH; c++) begin
        if (mon_en && bus.pwm_high[c] && !prev_high[c])
          check_eq("rise_gap_ok", 32'(off_cnt[c] >= ((dt_rise == 0) ? 1 : int'(dt_rise))), 32'd1);
        if (mon_en && bus.pwm_low[c] && !prev_low[c])
          check_eq("fall_gap_ok", 32'(off_cnt[c] >= ((dt_fall == 0) ? 1 : int'(dt_fall))), 32'd1);
        if (bus.pwm_high[c] || bus.pwm_low[c]) off_cnt[c] = 0;
        else if (off_cnt[c] < 1000) off_cnt[c] = off_cnt[c] + 1;
      end
    end
    prev_high = bus.pwm_high;
    prev_low  = bus.pwm_low;
  end

  initial begin
    for (int c = 0; c < NCH; c++) off_cnt[c] = 0;
    reset_n     = 1'b0;
    enable      = 1'b0;
    bus.pwm_in  = '0;
    dt_rise     = 8'd4;
    dt_fall     = 8'd2;
    fault_n     = 1'b1;
    fault_clr   = 1'b0;
    tick(3);
    chk_out("reset", 3'b000, 3'b000, 3'b000);
    check_eq("reset.fault", 32'(fault_latched), 32'd0);

    // Release with enable high: DEAD on first edge, LO after dt_fall=2
    enable  = 1'b1;
    reset_n = 1'b1;
    tick(1);
    chk_out("start.dead", 3'b000, 3'b000, 3'b111);
    tick(2);
    chk_out("start.lo", 3'b000, 3'b111, 3'b000);

    // ch0 0->1, dt_rise=4: low off after E+1, high on after E+5
    bus.pwm_in = 3'b001;
    tick(1);
    chk_out("rise.E", 3'b000, 3'b111, 3'b000);
    tick(1);
    chk_out("rise.E1", 3'b000, 3'b110, 3'b001);
    tick(3);
    chk_out("rise.E4", 3'b000, 3'b110, 3'b001);
    tick(1);
    chk_out("rise.E5", 3'b001, 3'b110, 3'b000);

    // Reverse with dt_fall=2
    bus.pwm_in = 3'b000;
    tick(2);
    chk_out("fall.E1", 3'b000, 3'b110, 3'b001);
    tick(1);
    chk_out("fall.E2", 3'b000, 3'b110, 3'b001);
    tick(1);
    chk_out("fall.E3", 3'b000, 3'b111, 3'b000);

    // dt_rise=0 gives exactly one dead cycle
    dt_rise    = 8'd0;
    bus.pwm_in = 3'b010;
    tick(2);
    chk_out("dt0.E1", 3'b000, 3'b101, 3'b010);
    tick(1);
    chk_out("dt0.E2", 3'b010, 3'b101, 3'b000);
    bus.pwm_in = 3'b000;
    tick(4);
    chk_out("dt0.back", 3'b000, 3'b111, 3'b000);

    // dt_rise=255: full 255 cycles; changing dt mid-DEAD has no effect
    dt_rise    = 8'd255;
    bus.pwm_in = 3'b100;
    tick(2);
    chk_out("dt255.E1", 3'b000, 3'b011, 3'b100);
    dt_rise = 8'd1;
    tick(254);
    chk_out("dt255.E255", 3'b000, 3'b011, 3'b100);
    tick(1);
    chk_out("dt255.E256", 3'b100, 3'b011, 3'b000);
    dt_rise    = 8'd4;
    bus.pwm_in = 3'b000;
    tick(4);
    chk_out("dt255.back", 3'b000, 3'b111, 3'b000);

    // One-cycle glitch during DEAD restarts the interval twice
    bus.pwm_in = 3'b001;
    tick(3);
    bus.pwm_in = 3'b000;
    tick(1);
    bus.pwm_in = 3'b001;
    tick(1);
    chk_out("glitch.G1", 3'b000, 3'b110, 3'b001);
    tick(2);
    chk_out("glitch.G3", 3'b000, 3'b110, 3'b001);
    tick(2);
    chk_out("glitch.G5", 3'b000, 3'b110, 3'b001);
    tick(1);
    chk_out("glitch.G6", 3'b001, 3'b110, 3'b000);

    // Fault while ch1 in HI
    bus.pwm_in = 3'b011;
    tick(6);
    chk_out("prefault", 3'b011, 3'b100, 3'b000);
    fault_n = 1'b0;
    tick(1);
    chk_out("fault.trip", 3'b000, 3'b000, 3'b000);
    check_eq("fault.set", 32'(fault_latched), 32'd1);
    fault_n = 1'b1;
    tick(2);
    check_eq("fault.hold", 32'(fault_latched), 32'd1);
    fault_n   = 1'b0;
    fault_clr = 1'b1;
    tick(1);
    check_eq("fault.clr_blocked", 32'(fault_latched), 32'd1);
    fault_n   = 1'b1;
    fault_clr = 1'b0;
    tick(1);
    check_eq("fault.still", 32'(fault_latched), 32'd1);
    chk_out("fault.off", 3'b000, 3'b000, 3'b000);
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    check_eq("fault.cleared", 32'(fault_latched), 32'd0);
    chk_out("fault.C", 3'b000, 3'b000, 3'b000);
    tick(1);
    chk_out("fault.C1", 3'b000, 3'b000, 3'b111);
    tick(2);
    chk_out("fault.C3", 3'b000, 3'b100, 3'b011);
    tick(2);
    chk_out("fault.C5", 3'b011, 3'b100, 3'b000);

    // enable dropped mid-HI, then re-entry through DEAD
    enable = 1'b0;
    tick(1);
    chk_out("en.off", 3'b000, 3'b000, 3'b000);
    enable = 1'b1;
    tick(1);
    chk_out("en.X", 3'b000, 3'b000, 3'b111);
    tick(3);
    chk_out("en.X3", 3'b000, 3'b100, 3'b011);
    tick(1);
    chk_out("en.X4", 3'b011, 3'b100, 3'b000);

    // Reset pulsed mid-DEAD: outputs drop without a clock edge
    enable = 1'b0;
    tick(1);
    enable = 1'b1;
    tick(2);
    chk_out("rst.pre", 3'b000, 3'b000, 3'b111);
    reset_n = 1'b0;
    #2;
    chk_out("rst.async", 3'b000, 3'b000, 3'b000);
    reset_n = 1'b1;
    tick(1);
    chk_out("rst.E1", 3'b000, 3'b000, 3'b111);
    tick(2);
    chk_out("rst.E3", 3'b000, 3'b100, 3'b011);
    tick(2);
    chk_out("rst.E5", 3'b000, 3'b100, 3'b011);
    tick(1);
    chk_out("rst.E6", 3'b011, 3'b100, 3'b000);

    // Random PWM on all channels with a few fixed dead-time pairs
    for (int b = 0; b < 3; b++) begin
      tick(300);
      dt_rise = 8'($urandom_range(0, 6));
      dt_fall = 8'($urandom_range(0, 6));
      tick(1);
      mon_en = 1'b1;
      for (int k = 0; k < 300; k++) begin
        bus.pwm_in = 3'($urandom);
        tick(($urandom_range(0, 3) == 0) ? 1 : int'($urandom_range(1, 9)));
      end
      mon_en = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
